// File: rtl/branch_update_ctrl_if.sv
// Resolution, predictor-update and redirect signals of the branch update sequencer.
// The slave modport is the controller's view; master is the EX/predictor side.
interface branch_update_ctrl_if #(
    parameter int WIDTH      = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                  res_valid;
    logic                  res_ready;
    logic                  res_miss;
    logic [WIDTH-1:0]      res_line_index;
    logic [ADDR_WIDTH-1:0] res_pc;
    logic                  res_taken;
    logic [ADDR_WIDTH-1:0] res_target;
    logic                  res_pred_taken;
    logic [ADDR_WIDTH-1:0] res_pred_target;
    logic                  upd_stall;

    logic                  replace_en;
    logic [ADDR_WIDTH-1:0] replace_pc;
    logic [ADDR_WIDTH-1:0] replace_pc_target;
    logic                  static_branch_predict;
    logic                  fresh_en;
    logic [WIDTH-1:0]      fresh_line_index;
    logic                  dynamic_branch_predict;

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [31:0]           mispredict_cnt;

    modport slave (
        input  res_valid, res_miss, res_line_index, res_pc, res_taken,
               res_target, res_pred_taken, res_pred_target, upd_stall,
        output res_ready, replace_en, replace_pc, replace_pc_target,
               static_branch_predict, fresh_en, fresh_line_index,
               dynamic_branch_predict, redirect_valid, redirect_pc, mispredict_cnt
    );

    modport master (
        output res_valid, res_miss, res_line_index, res_pc, res_taken,
               res_target, res_pred_taken, res_pred_target, upd_stall,
        input  res_ready, replace_en, replace_pc, replace_pc_target,
               static_branch_predict, fresh_en, fresh_line_index,
               dynamic_branch_predict, redirect_valid, redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_update_ctrl.sv
// Purpose: queue resolved branches into predictor replace/fresh updates, merging same-PC misses; flag redirects.
// Latency: update strobe one cycle after accept (when alone and unstalled); redirect registered, one cycle.
// Backpressure: res_ready drops only when full with no pop and no merge hit; upd_stall holds the queue head.
module branch_update_ctrl #(
    parameter int WIDTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_update_ctrl_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic                  rep;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
        logic                  taken;
        logic [WIDTH-1:0]      line_index;
    } upd_t;

    upd_t                  mem [DEPTH];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [CW-1:0]         count_q;
    logic                  redirect_vld_q;
    logic [ADDR_WIDTH-1:0] redirect_pc_q;
    logic [31:0]           cnt_q;

    logic                  pop;
    logic                  push;
    logic                  merge;
    logic                  merge_hit;
    logic                  ready;
    logic                  accept;
    logic                  mispredict;
    logic [DEPTH-1:0]      match_vec;
    logic [PW-1:0]         match_idx;
    upd_t                  head_e;
    upd_t                  new_e;

    assign head_e = mem[head_q];
    assign pop    = (count_q != '0) & ~bus.upd_stall;

    // An entry is live when its distance from head is below count; the head
    // leaving this cycle is excluded so the resolution is enqueued afresh.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        logic [PW-1:0] off;
        assign off = PW'(g) - head_q;
        assign match_vec[g] = ({1'b0, off} < count_q) && mem[g].rep &&
                              (mem[g].pc == bus.res_pc) &&
                              !(pop && (PW'(g) == head_q));
    end

    always_comb begin
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_vec[i]) match_idx = PW'(i);
        end
    end

    assign merge_hit  = bus.res_miss & (|match_vec);
    assign ready      = (count_q < CW'(DEPTH)) | pop | merge_hit;
    assign accept     = bus.res_valid & ready;
    assign push       = accept & ~merge_hit;
    assign merge      = accept & merge_hit;
    assign mispredict = (bus.res_taken != bus.res_pred_taken) |
                        (bus.res_taken & (bus.res_target != bus.res_pred_target));

    always_comb begin
        new_e            = '0;
        new_e.rep        = bus.res_miss;
        new_e.pc         = bus.res_pc;
        new_e.target     = bus.res_target;
        new_e.taken      = bus.res_taken;
        new_e.line_index = bus.res_line_index;
    end

    // Entry storage needs no reset: liveness is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= new_e;
        end else if (merge) begin
            mem[match_idx].target <= bus.res_target;
            mem[match_idx].taken  <= bus.res_taken;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            redirect_vld_q <= 1'b0;
            redirect_pc_q  <= '0;
            cnt_q          <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            redirect_vld_q <= accept & mispredict;
            if (accept & mispredict) begin
                redirect_pc_q <= bus.res_taken ? bus.res_target
                                               : bus.res_pc + ADDR_WIDTH'(8);
                if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign bus.res_ready              = ready;
    assign bus.replace_en             = pop & head_e.rep;
    assign bus.replace_pc             = head_e.pc;
    assign bus.replace_pc_target      = head_e.target;
    assign bus.static_branch_predict  = head_e.taken;
    assign bus.fresh_en               = pop & ~head_e.rep;
    assign bus.fresh_line_index       = head_e.line_index;
    assign bus.dynamic_branch_predict = head_e.taken;
    assign bus.redirect_valid         = redirect_vld_q;
    assign bus.redirect_pc            = redirect_pc_q;
    assign bus.mispredict_cnt         = cnt_q;
endmodule

// File: doc/branch_update_ctrl.md
# branch_update_ctrl

Sequencer between EX-stage branch resolution and the `branch_predict` table. It accepts one resolved branch per cycle and raises a front-end redirect on any misprediction. It buffers predictor updates in a small in-order queue and issues them one per cycle as `replace_*` (table miss) or `fresh_*` (table hit) strobes when the predictor is not busy. Same-PC miss updates already in the queue are merged, so the table never receives duplicate entries.

## Interface
- `WIDTH`, 4: predictor line-index width.
- `ADDR_WIDTH`, 32: PC width.
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `res_valid`  in  1  EX presents a resolved branch/jump.
- `res_ready`  out  1  controller accepts this cycle.
- `res_miss`  in  1  the IF lookup missed the table.
- `res_line_index`  in  WIDTH  line hit at IF; meaningful only when `res_miss`=0.
- `res_pc`  in  ADDR_WIDTH  PC of the branch.
- `res_taken`  in  1  actual direction.
- `res_target`  in  ADDR_WIDTH  actual taken target.
- `res_pred_taken`  in  1  direction used at IF.
- `res_pred_target`  in  ADDR_WIDTH  target used at IF.
- `upd_stall`  in  1  predictor cannot take an update this cycle.
- `replace_en`, `replace_pc`, `replace_pc_target`, `static_branch_predict`  out  1/ADDR_WIDTH/ADDR_WIDTH/1  replace port of the predictor.
- `fresh_en`, `fresh_line_index`, `dynamic_branch_predict`  out  1/WIDTH/1  fresh port of the predictor.
- `redirect_valid`  out  1  flush the front end.
- `redirect_pc`  out  ADDR_WIDTH  correct fetch PC.
- `mispredict_cnt`  out  32  count of mispredictions; saturates at 0xFFFFFFFF.

## Operation
- **Acceptance.** A resolution is accepted when `res_valid & res_ready`.
- **Ready.** `res_ready` = (count < DEPTH) | pop_this_cycle | merge_hit.
- **Entry fields.** Each entry holds kind, pc, target, taken and line_index. Kind is REPLACE when `res_miss`=1, FRESH otherwise.
- **Merge.** An accepted REPLACE whose `res_pc` equals the pc of a valid queued REPLACE entry overwrites that entry's target and taken, and count is unchanged.
  - If the matching entry is the head being popped in the same cycle, there is no merge; the resolution is enqueued normally.
  - At most one entry can match, because merging keeps queue PCs unique.
  - FRESH entries never merge.
- **Issue.** When the queue is non-empty and `upd_stall`=0, the head is popped. In that cycle, combinationally from the head:
  - REPLACE head: `replace_en`=1, `replace_pc`=pc, `replace_pc_target`=target, `static_branch_predict`=taken.
  - FRESH head: `fresh_en`=1, `fresh_line_index`=line_index, `dynamic_branch_predict`=taken.
- **Strobe exclusivity.** `replace_en` and `fresh_en` are never both 1. Both are 0 when the queue is empty or `upd_stall`=1. Data outputs are don't-care when their strobe is 0.
- **Mispredict.** mispredict = (`res_taken` != `res_pred_taken`) | (`res_taken` & `res_target` != `res_pred_target`).
- **Redirect.** On an accepted mispredict, `redirect_valid` is registered high for exactly one cycle. `redirect_pc` = `res_target` when taken, otherwise `res_pc` + 8 (modulo 2^ADDR_WIDTH).
- **Counter.** `mispredict_cnt` increments on each accepted mispredict and holds at saturation.
- **Redirect vs queue.** The redirect does not depend on queue state; the update for the same branch still issues from the queue.

## Timing
- **Reset** (`reset`=0, asynchronous): queue empty, pointers and count 0, `redirect_valid`=0, `redirect_pc`=0, `mispredict_cnt`=0, `replace_en`=`fresh_en`=0. `res_ready`=1 once reset deasserts.
- **Reset mid-operation:** all queued updates are discarded and no strobe is issued.
- **Update latency:** accepted at edge E, the entry is at the head from E. If it is the only entry and `upd_stall`=0, its strobe is asserted in cycle E+1.
- **Redirect latency:** `redirect_valid` is asserted in cycle E+1, independent of stall.
- **Throughput:** one accept and one pop per cycle. Simultaneous push and pop at count=DEPTH is allowed, and count stays DEPTH.
- **Stall:** while `upd_stall`=1 the head is held and its strobes stay deasserted. The queue keeps accepting until full, then `res_ready`=0, except that a merge hit is still accepted.
- **Ordering:** updates issue in acceptance order. A merged entry keeps its original queue position.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided from count, which is log2(DEPTH)+1 bits.

## Test plan
- **Reset:** assert `reset`=0 mid-stream with 3 entries queued; release -> no strobe issued, `mispredict_cnt`=0, `res_ready`=1.
- **Miss, not taken:** miss, pc=0x1000, taken=0, pred_taken=0 -> next cycle `replace_en`=1, `replace_pc`=0x1000, `static_branch_predict`=0; `redirect_valid`=0.
- **Mispredicted hit:** hit line 5, pc=0x2000, taken=1, target=0x3000, pred_taken=0 -> next cycle `redirect_valid`=1, `redirect_pc`=0x3000, `fresh_en`=1, `fresh_line_index`=5, `dynamic_branch_predict`=1, `mispredict_cnt`=1.
- **Stall and full:** `upd_stall`=1; push 4 distinct misses -> `res_ready`=0 on the 5th distinct PC. Push a 5th with pc equal to the 2nd, target=0x4444 -> accepted, count stays 4. Release stall -> 4 replace strobes on consecutive cycles, in order, the 2nd carrying target 0x4444.
- **Not-taken redirect wrap:** pred_taken=1, taken=0, pc=0xFFFFFFFC -> `redirect_pc`=0x00000004.
- **Counter saturation:** preload `mispredict_cnt` via force to 0xFFFFFFFE; apply 3 mispredicts -> counter ends at 0xFFFFFFFF.
